// File: rtl/bitmap_pkg.sv
// -----------------------------------------------------------------------------
// bitmap_pkg
// Shared types and constants for the 320x240, 3-bit RGB bitmap draw path.
//   SCREEN_W / SCREEN_H : drawable area, used as the clip bounds
//   bm_x_t / bm_y_t     : frame-buffer column / row address types
//   bm_xsum_t/bm_ysum_t : one bit wider, for origin+extent sums
//   bm_color_t          : {R,G,B} pixel colour, with named colour constants
//   draw_state_e        : draw engine states IDLE / DRAW / DONE
// -----------------------------------------------------------------------------
package bitmap_pkg;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;

    typedef logic [8:0] bm_x_t;
    typedef logic [7:0] bm_y_t;
    typedef logic [2:0] bm_color_t;
    typedef logic [9:0] bm_xsum_t;
    typedef logic [8:0] bm_ysum_t;

    localparam bm_color_t BLACK   = 3'b000;
    localparam bm_color_t BLUE    = 3'b001;
    localparam bm_color_t GREEN   = 3'b010;
    localparam bm_color_t CYAN    = 3'b011;
    localparam bm_color_t RED     = 3'b100;
    localparam bm_color_t MAGENTA = 3'b101;
    localparam bm_color_t YELLOW  = 3'b110;
    localparam bm_color_t WHITE   = 3'b111;

    // Raw state encodings kept as plain constants so older code that
    // compares against bit patterns keeps working alongside the enum.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        DRAW = ST_DRAW,
        DONE = ST_DONE
    } draw_state_e;

endpackage

// File: rtl/bitmap_rect_clip.sv
// -----------------------------------------------------------------------------
// bitmap_rect_clip
// Combinational reduction of a rectangle command (x0, y0, w, h) to its
// exclusive end coordinates and an "empty" flag.
//   x0_i, y0_i   : top-left corner
//   w_i, h_i     : extent in pixels (0 legal)
//   x_end_o      : exclusive end column (10-bit)
//   y_end_o      : exclusive end row (9-bit)
//   empty_o      : rectangle produces no writes
// Build option BITMAP_RECT_CLIP_EN: when defined, the rectangle is clipped
// to SCREEN_W x SCREEN_H; when undefined, the raw sums are passed through
// and only a zero extent makes the rectangle empty.
// -----------------------------------------------------------------------------
module bitmap_rect_clip
    import bitmap_pkg::*;
(
    input  bm_x_t    x0_i,
    input  bm_y_t    y0_i,
    input  bm_x_t    w_i,
    input  bm_y_t    h_i,
    output bm_xsum_t x_end_o,
    output bm_ysum_t y_end_o,
    output logic     empty_o
);

    bm_xsum_t x_sum;
    bm_ysum_t y_sum;

    assign x_sum = {1'b0, x0_i} + {1'b0, w_i};
    assign y_sum = {1'b0, y0_i} + {1'b0, h_i};

`ifdef BITMAP_RECT_CLIP_EN
    localparam bm_xsum_t X_LIM = bm_xsum_t'(SCREEN_W);
    localparam bm_ysum_t Y_LIM = bm_ysum_t'(SCREEN_H);

    always_comb begin
        x_end_o = (x_sum > X_LIM) ? X_LIM : x_sum;
        y_end_o = (y_sum > Y_LIM) ? Y_LIM : y_sum;
        // An origin at or beyond the edge leaves nothing on screen even
        // though the min() above would give end < origin.
        empty_o = (w_i == '0) || (h_i == '0) ||
                  ({1'b0, x0_i} >= X_LIM) || ({1'b0, y0_i} >= Y_LIM);
    end
`else
    always_comb begin
        x_end_o = x_sum;
        y_end_o = y_sum;
        empty_o = (w_i == '0) || (h_i == '0);
    end
`endif

endmodule

// File: rtl/bitmap_rect_drawer.sv
// -----------------------------------------------------------------------------
// bitmap_rect_drawer
// Filled-rectangle draw engine feeding the bitmap frame buffer write port.
// Accepts one command on a valid/ready handshake and scans the (optionally
// clipped) rectangle row-major, one pixel write per clock.
//   clk, reset            : clock, synchronous active-high reset
//   cmd_valid / cmd_ready : command handshake (ready only while idle)
//   cmd_x0, cmd_y0        : top-left corner
//   cmd_w, cmd_h          : extent in pixels (0 legal)
//   cmd_color             : fill colour {R,G,B}
//   x, y, color, wr_en    : pixel write port to the frame buffer
//   busy                  : command in progress (DRAW or DONE)
//   done                  : one-cycle completion pulse
// Build option BITMAP_RECT_CLIP_EN selects clipping to the screen (see
// bitmap_rect_clip); otherwise x/y wrap modulo 512/256.
// All outputs are registered.
// -----------------------------------------------------------------------------
module bitmap_rect_drawer
    import bitmap_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [8:0] cmd_x0,
    input  logic [7:0] cmd_y0,
    input  logic [8:0] cmd_w,
    input  logic [7:0] cmd_h,
    input  logic [2:0] cmd_color,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic [2:0] color,
    output logic       wr_en,
    output logic       busy,
    output logic       done
);

    // -------------------------------------------------------------------------
    // Clip of the incoming command (only meaningful in the accept cycle)
    // -------------------------------------------------------------------------
    bm_xsum_t clip_x_end;
    bm_ysum_t clip_y_end;
    logic     clip_empty;
    bm_xsum_t span_x;
    bm_ysum_t span_y;

    bitmap_rect_clip u_clip (
        .x0_i    (cmd_x0),
        .y0_i    (cmd_y0),
        .w_i     (cmd_w),
        .h_i     (cmd_h),
        .x_end_o (clip_x_end),
        .y_end_o (clip_y_end),
        .empty_o (clip_empty)
    );

    // Scan extents; only used when the rectangle is non-empty, where they
    // are guaranteed to be at least 1.
    assign span_x = clip_x_end - {1'b0, cmd_x0};
    assign span_y = clip_y_end - {1'b0, cmd_y0};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    draw_state_e state_q,    state_d;
    bm_x_t       x_q,        x_d;
    bm_y_t       y_q,        y_d;
    bm_color_t   color_q,    color_d;
    logic        wr_en_q,    wr_en_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        ready_q,    ready_d;
    bm_x_t       x0_q,       x0_d;
    bm_xsum_t    span_x_q,   span_x_d;
    // Pixels / rows still to go after the current one. Counting down keeps
    // termination independent of coordinate wrap in the unclipped build.
    bm_xsum_t    col_left_q, col_left_d;
    bm_ysum_t    row_left_q, row_left_d;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        color_d    = color_q;
        wr_en_d    = wr_en_q;
        busy_d     = busy_q;
        done_d     = done_q;
        ready_d    = ready_q;
        x0_d       = x0_q;
        span_x_d   = span_x_q;
        col_left_d = col_left_q;
        row_left_d = row_left_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    color_d  = cmd_color;
                    x0_d     = cmd_x0;
                    span_x_d = span_x;
                    if (clip_empty) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = DRAW;
                        wr_en_d    = 1'b1;
                        x_d        = cmd_x0;
                        y_d        = cmd_y0;
                        col_left_d = span_x - 10'd1;
                        row_left_d = span_y - 9'd1;
                    end
                end
            end

            DRAW: begin
                if (col_left_q == '0) begin
                    if (row_left_q == '0) begin
                        // The pixel now on the port is the last one.
                        state_d = DONE;
                        wr_en_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        x_d        = x0_q;
                        y_d        = y_q + 8'd1;
                        col_left_d = span_x_q - 10'd1;
                        row_left_d = row_left_q - 9'd1;
                    end
                end else begin
                    x_d        = x_q + 9'd1;
                    col_left_d = col_left_q - 10'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            color_q    <= BLACK;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            x0_q       <= '0;
            span_x_q   <= '0;
            col_left_q <= '0;
            row_left_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            color_q    <= color_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            x0_q       <= x0_d;
            span_x_q   <= span_x_d;
            col_left_q <= col_left_d;
            row_left_q <= row_left_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign color     = color_q;
    assign wr_en     = wr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = ready_q;

endmodule

// File: tb/tb_bitmap_rect_drawer.sv
// -----------------------------------------------------------------------------
// tb_bitmap_rect_drawer
// Directed and randomized rectangle commands against a pixel-list reference
// model. Inputs change and outputs are sampled on the falling clock edge.
// Honours BITMAP_RECT_CLIP_EN the same way as the design build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bitmap_rect_drawer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_x0;
    logic [7:0] cmd_y0;
    logic [8:0] cmd_w;
    logic [7:0] cmd_h;
    logic [2:0] cmd_color;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] color;
    logic       wr_en;
    logic       busy;
    logic       done;

    bitmap_rect_drawer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .x         (x),
        .y         (y),
        .color     (color),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int px;
        int py;
    } px_t;

    px_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: the ordered list of pixels a command must write.
    task automatic build_expected(input int x0, input int y0, input int w, input int h);
        int xe;
        int ye;
        bit empty;
        exp_q.delete();
`ifdef BITMAP_RECT_CLIP_EN
        xe    = (x0 + w > 320) ? 320 : x0 + w;
        ye    = (y0 + h > 240) ? 240 : y0 + h;
        empty = (w == 0) || (h == 0) || (x0 >= 320) || (y0 >= 240);
`else
        xe    = x0 + w;
        ye    = y0 + h;
        empty = (w == 0) || (h == 0);
`endif
        if (!empty) begin
            for (int yy = y0; yy < ye; yy++) begin
                for (int xx = x0; xx < xe; xx++) begin
                    exp_q.push_back('{px: xx % 512, py: yy % 256});
                end
            end
        end
    endtask

    // Called on a falling edge; returns on the falling edge where cmd_ready
    // has come back, so consecutive calls exercise minimum accept spacing.
    // keep_valid leaves cmd_valid asserted with a small follow-up command
    // (1,1,2,1,colour 5) presented while the engine is busy.
    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input int c, input bit keep_valid);
        int  n;
        int  budget;
        int  f0;
        bit  pix_bad;
        build_expected(x0, y0, w, h);
        n = exp_q.size();
        cmd_x0    = 9'(x0);
        cmd_y0    = 8'(y0);
        cmd_w     = 9'(w);
        cmd_h     = 8'(h);
        cmd_color = 3'(c);
        cmd_valid = 1'b1;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("ready_before_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        if (keep_valid) begin
            cmd_x0    = 9'd1;
            cmd_y0    = 8'd1;
            cmd_w     = 9'd2;
            cmd_h     = 8'd1;
            cmd_color = 3'd5;
        end else begin
            cmd_valid = 1'b0;
        end
        pix_bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (!pix_bad) begin
                f0 = failures;
                chk($sformatf("pixel%0d_wr_x_y_color_done_busy_ready", i),
                    32'({wr_en, x, y, color, done, busy, cmd_ready}),
                    32'({1'b1, 9'(exp_q[i].px), 8'(exp_q[i].py), 3'(c), 1'b0, 1'b1, 1'b0}));
                if (failures != f0) pix_bad = 1'b1;
            end
        end
        if (n > 0) @(negedge clk);
        chk("done_cycle_wr_done_busy_ready", 32'({wr_en, done, busy, cmd_ready}), 32'b0110);
        @(negedge clk);
        chk("idle_cycle_wr_done_busy_ready", 32'({wr_en, done, busy, cmd_ready}), 32'b0001);
        $display("cmd x0=%0d y0=%0d w=%0d h=%0d color=%0d expected_writes=%0d",
                 x0, y0, w, h, c, n);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;
        repeat (2) @(negedge clk);
        chk("reset_x_y_color_wr_done_busy_ready",
            32'({x, y, color, wr_en, done, busy, cmd_ready}), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Single pixel, small rectangle, clipped corner, empties.
        run_cmd(10, 20, 1, 1, 4, 1'b0);
        run_cmd(5, 7, 3, 2, 3, 1'b0);
        run_cmd(318, 238, 5, 4, 6, 1'b0);
        run_cmd(10, 10, 0, 5, 1, 1'b0);
        run_cmd(10, 10, 5, 0, 2, 1'b0);
        run_cmd(320, 10, 3, 1, 7, 1'b0);

        // Full-screen clear with a follow-up command held on cmd_valid.
        run_cmd(0, 0, 320, 240, 0, 1'b1);
        run_cmd(1, 1, 2, 1, 5, 1'b0);

        // Reset on the third write of a 4x4 rectangle.
        build_expected(50, 60, 4, 4);
        cmd_x0    = 9'd50;
        cmd_y0    = 8'd60;
        cmd_w     = 9'd4;
        cmd_h     = 8'd4;
        cmd_color = 3'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("rst_rect_pixel%0d", i),
                32'({wr_en, x, y, color}),
                32'({1'b1, 9'(exp_q[i].px), 8'(exp_q[i].py), 3'd2}));
        end
        reset = 1'b1;
        @(negedge clk);
        chk("after_reset_x_y_wr_done_busy_ready",
            32'({x, y, wr_en, done, busy, cmd_ready}), 32'b0001);
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset_no_done", 32'({wr_en, done, busy, cmd_ready}), 32'b0001);
        $display("cmd x0=50 y0=60 w=4 h=4 color=2 interrupted by reset after 3 writes");
        run_cmd(100, 30, 3, 2, 6, 1'b0);

        // Randomized commands, biased towards the screen edges.
        for (int k = 0; k < 24; k++) begin
            int rx;
            int ry;
            if (k % 3 == 0) begin
                rx = $urandom_range(505, 311);
                ry = $urandom_range(255, 232);
            end else begin
                rx = $urandom_range(511, 0);
                ry = $urandom_range(255, 0);
            end
            run_cmd(rx, ry, $urandom_range(12, 0), $urandom_range(6, 0),
                    $urandom_range(7, 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitmap_rect_drawer.md
Name: bitmap_rect_drawer

Overview:
- Upstream draw engine for the 320x240, 3-bit RGB bitmap frame buffer.
- Accepts one filled-rectangle command at a time over a valid/ready handshake.
- Emits one pixel write per clock on x/y/color/wr_en, which connect directly to the frame buffer's user-side write port in the same clk domain.
- Game logic, e.g. paddles, ball and screen clear, issues rectangles; this block does the row-major scan.

Parameters:
- SCREEN_W, 320, drawable width in pixels; the clip bound for x.
- SCREEN_H, 240, drawable height in pixels; the clip bound for y.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_x0  in  9  left column.
- cmd_y0  in  8  top row.
- cmd_w  in  9  width in pixels; 0 is legal.
- cmd_h  in  8  height in pixels; 0 is legal.
- cmd_color  in  3  fill colour {R,G,B}.
- x  out  9  write column.
- y  out  8  write row.
- color  out  3  write colour.
- wr_en  out  1  pixel write strobe.
- busy  out  1  high in DRAW and DONE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- All outputs are registered.
- Reset values: x=0, y=0, color=0, wr_en=0, done=0, busy=0, cmd_ready=1, state=IDLE.
- States:
  - IDLE -> DRAW on accept (cmd_valid && cmd_ready) when the clipped rectangle is non-empty.
  - IDLE -> DONE on accept when the clipped rectangle is empty.
  - DRAW -> DONE in the cycle the last pixel is written.
  - DONE -> IDLE unconditionally.
- Command capture: cmd_* are registered on the accept edge and are ignored at all other times.
- Clipping, computed at accept time:
  - x_end = min(x0+w, SCREEN_W), using a 10-bit sum.
  - y_end = min(y0+h, SCREEN_H), using a 9-bit sum.
  - The rectangle is empty if w==0, h==0, x0>=SCREEN_W or y0>=SCREEN_H.
- Latency: accept on edge N; first write (x=x0, y=y0, wr_en=1) is visible in cycle N+1.
- Scan order: row-major, one pixel per cycle, no gaps.
  - x increments each cycle.
  - At x==x_end-1, x returns to x0 and y increments.
- Write count: the last write is at (x_end-1, y_end-1). Exactly (x_end-x0)*(y_end-y0) cycles have wr_en=1.
- Completion: done=1 and wr_en=0 in the cycle after the last write, i.e. while in DONE; cmd_ready returns high the following cycle.
- Empty command: zero writes. done pulses in cycle N+1.
- Back-to-back commands: minimum spacing between consecutive accepts is the pixel count + 2 cycles.
- color holds the captured cmd_color for the entire command.
- No backpressure: the write port always accepts.
- Reset mid-DRAW: at the reset edge, wr_en goes to 0, state goes to IDLE, no done pulse is produced, and the partial rectangle is left in the frame buffer.
- cmd_valid is ignored while cmd_ready=0; no command is queued.

Optional Feature:
- Macro: BITMAP_RECT_CLIP_EN.
- Defined: clipping exactly as described above.
- Undefined: no clipping.
  - x_end = x0+w and y_end = y0+h.
  - The x counter wraps modulo 512 and the y counter wraps modulo 256.
  - Exactly w*h writes are issued; out-of-screen writes land in the unused frame-buffer address space or wrap.
  - Empty only when w==0 or h==0.

Decomposition:
- Package bitmap_pkg:
  - SCREEN_W / SCREEN_H constants.
  - typedef logic [8:0] bm_x_t, logic [7:0] bm_y_t, logic [2:0] bm_color_t.
  - Named colour constants (BLACK=3'b000 ... WHITE=3'b111).
  - Enum typedef for the draw states IDLE/DRAW/DONE.
- Sub-module bitmap_rect_clip: combinational clip of (x0,y0,w,h) to (x_end, y_end, empty). This is the only piece that varies with BITMAP_RECT_CLIP_EN.

Test Plan:
1. Single pixel: x0=10, y0=20, w=1, h=1, color=3'b100.
   -> one write at (10,20) color=4 in cycle N+1; done at N+2; cmd_ready high at N+3.
2. 3x2 rectangle at (5,7).
   -> 6 consecutive writes in the order (5,7)(6,7)(7,7)(5,8)(6,8)(7,8); no gaps; done the cycle after the last write.
3. Clipped, with BITMAP_RECT_CLIP_EN: x0=318, y0=238, w=5, h=4.
   -> 4 writes: (318,238)(319,238)(318,239)(319,239).
   -> Without the macro: 20 writes, x covering 318..322, y covering 238..241.
4. Empty commands: w=0; h=0; and x0=320 (with clip).
   -> zero wr_en cycles; done pulses at N+1 for each.
5. Full-screen clear: (0,0,320,240), color=0.
   -> exactly 76800 writes; last at (319,239); cmd_valid held high during busy is not accepted until cmd_ready rises.
6. Reset asserted on the 3rd write of a 4x4 rectangle.
   -> wr_en=0 from the next cycle, no done, cmd_ready=1.
   -> A new command issued afterwards draws correctly from its own origin.
